// File: rtl/mon_pkg.sv
// Shared types for the data-memory write monitor: run states and the end-of-test signature table.
package mon_pkg;

    localparam int unsigned NSIG  = 5;
    localparam int unsigned LOG_W = 48;

    typedef struct packed {
        logic [63:0] adr;
        logic [63:0] dat;
    } sig_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_FAIL
    } mon_state_t;

    function automatic sig_t sig_at(input int unsigned i);
        case (i)
            0:       return '{adr: 64'd100, dat: 64'd7};
            1:       return '{adr: 64'd508, dat: 64'd7};
            2:       return '{adr: 64'd80,  dat: 64'd1};
            3:       return '{adr: 64'd320, dat: 64'd4950};
            4:       return '{adr: 64'd100, dat: 64'd6};
            default: return '{adr: '0, dat: '0};
        endcase
    endfunction

endpackage

// File: rtl/wlog_fifo.sv
// Store-log FIFO: register array with extra-MSB pointers; head shown on rdata (zero when empty).
module wlog_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop on a full log frees the head slot in the same edge, so the push may reuse it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_write_monitor.sv
// Run monitor on the CPU store port: signature match, watchdog, cycle/store counters and a store log.
module mem_write_monitor
    import mon_pkg::*;
#(
    parameter int unsigned WATCHDOG  = 500,
    parameter int unsigned DRAIN     = 10,
    parameter int unsigned LOG_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        memwrite,
    input  logic [63:0]       dataadr,
    input  logic [63:0]       writedata,
    input  logic              log_pop,
    output logic              log_valid,
    output logic [LOG_W-1:0]  log_data,
    output logic              log_ovf,
    output logic              done,
    output logic              pass,
    output logic [2:0]        pass_id,
    output logic [31:0]       cycle_count,
    output logic [31:0]       store_count
);

    localparam int unsigned          DW         = $clog2(DRAIN + 1);
    localparam logic [DW-1:0]        DRAIN_LAST = DW'(DRAIN - 1);
    localparam logic [31:0]          WD_LAST    = 32'(WATCHDOG - 1);

    mon_state_t  state;
    logic [DW-1:0] drain_cnt;
    logic        store;
    logic        active;
    logic        push;
    logic        hit;
    logic [2:0]  hit_id;
    logic        log_full;
    logic        log_empty;

    assign store  = |memwrite;
    assign active = (state == ST_RUN) || (state == ST_DRAIN);
    assign push   = store && active;

    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int unsigned i = 0; i < NSIG; i++) begin
            if (!hit && store && dataadr == sig_at(i).adr && writedata == sig_at(i).dat) begin
                hit    = 1'b1;
                hit_id = 3'(i);
            end
        end
    end

    wlog_fifo #(
        .WIDTH (LOG_W),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (log_pop),
        .wdata ({dataadr[15:0], writedata[31:0]}),
        .rdata (log_data),
        .full  (log_full),
        .empty (log_empty)
    );

    assign log_valid = !log_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            drain_cnt   <= '0;
            cycle_count <= '0;
            store_count <= '0;
            pass_id     <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            log_ovf     <= 1'b0;
        end else begin
            if (push) begin
                store_count <= store_count + 32'd1;
            end
            if (push && log_full && !log_pop) begin
                log_ovf <= 1'b1;
            end
            case (state)
                ST_RUN: begin
                    cycle_count <= cycle_count + 32'd1;
                    // A match on the watchdog's last cycle still counts as a pass.
                    if (hit) begin
                        state     <= ST_DRAIN;
                        pass_id   <= hit_id;
                        drain_cnt <= '0;
                    end else if (cycle_count == WD_LAST) begin
                        state <= ST_FAIL;
                        done  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_monitor.sv
// Scoreboard bench for mem_write_monitor: directed stores, queued expectations, decoupled monitor.
module tb_mem_write_monitor;

    typedef struct {
        logic        pass;
        logic [2:0]  id;
        logic [31:0] cc;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  memwrite;
    logic [63:0] dataadr;
    logic [63:0] writedata;
    logic        log_pop;
    logic        log_valid;
    logic [47:0] log_data;
    logic        log_ovf;
    logic        done;
    logic        pass;
    logic [2:0]  pass_id;
    logic [31:0] cycle_count;
    logic [31:0] store_count;

    res_t        exp_res[$];
    logic [47:0] exp_log[$];
    int          occ;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        prev_done = 1'b0;

    always #5 clk = ~clk;

    mem_write_monitor #(
        .WATCHDOG  (500),
        .DRAIN     (10),
        .LOG_DEPTH (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .log_pop     (log_pop),
        .log_valid   (log_valid),
        .log_data    (log_data),
        .log_ovf     (log_ovf),
        .done        (done),
        .pass        (pass),
        .pass_id     (pass_id),
        .cycle_count (cycle_count),
        .store_count (store_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares log heads on each accepted pop and the result on each rise of done.
    always @(negedge clk) begin : monitor
        res_t r;
        if (log_pop && log_valid) begin
            if (exp_log.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL log_unexpected: got %0h, expected no entry", log_data);
            end else begin
                chk("log_data", 64'(log_data), 64'(exp_log.pop_front()));
            end
        end
        if (done && !prev_done) begin
            if (exp_res.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_unexpected: got done=1 pass=%0b, expected no result", pass);
            end else begin
                r = exp_res.pop_front();
                chk("res_pass", 64'(pass), 64'(r.pass));
                chk("res_id", 64'(pass_id), 64'(r.id));
                chk("res_cycles", 64'(cycle_count), 64'(r.cc));
            end
        end
        prev_done = done;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_pass_id"}, 64'(pass_id), 64'd0);
        chk({tag, "_cycles"}, 64'(cycle_count), 64'd0);
        chk({tag, "_stores"}, 64'(store_count), 64'd0);
        chk({tag, "_log_valid"}, 64'(log_valid), 64'd0);
        chk({tag, "_log_data"}, 64'(log_data), 64'd0);
        chk({tag, "_log_ovf"}, 64'(log_ovf), 64'd0);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        memwrite = 2'b00;
        log_pop  = 1'b0;
        step(3);
        exp_log.delete();
        occ = 0;
        chk_zero("reset");
        reset = 1'b1;
    endtask

    // One store cycle in RUN/DRAIN, optionally with a same-cycle pop; models log occupancy.
    task automatic store(input logic [63:0] adr, input logic [63:0] dat,
                         input logic [1:0] mw, input logic pop);
        memwrite  = mw;
        dataadr   = adr;
        writedata = dat;
        log_pop   = pop;
        if (pop && occ > 0) occ--;
        if (occ < 8) begin
            exp_log.push_back({adr[15:0], dat[31:0]});
            occ++;
        end
        step(1);
        memwrite = 2'b00;
        log_pop  = 1'b0;
    endtask

    task automatic pop_n(input int n);
        log_pop = 1'b1;
        step(n);
        log_pop = 1'b0;
        occ -= n;
    endtask

    initial begin : timeout
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b0;
        memwrite  = 2'b00;
        dataadr   = '0;
        writedata = '0;
        log_pop   = 1'b0;
        occ       = 0;

        // Watchdog expiry with no stores.
        do_reset();
        exp_res.push_back('{pass: 1'b0, id: 3'd0, cc: 32'd500});
        step(499);
        chk("wd_done_early", 64'(done), 64'd0);
        chk("wd_cycles_499", 64'(cycle_count), 64'd499);
        step(1);
        chk("wd_done", 64'(done), 64'd1);
        chk("wd_pass", 64'(pass), 64'd0);
        chk("wd_cycles", 64'(cycle_count), 64'd500);
        step(3);
        chk("wd_frozen", 64'(cycle_count), 64'd500);
        chk("wd_absorb", 64'(done), 64'd1);

        // Signature 0 at cycle 20; pass DRAIN cycles after the match edge.
        do_reset();
        step(20);
        chk("m0_cycles_pre", 64'(cycle_count), 64'd20);
        exp_res.push_back('{pass: 1'b1, id: 3'd0, cc: 32'd21});
        store(64'd100, 64'd7, 2'b01, 1'b0);
        chk("m0_cycles", 64'(cycle_count), 64'd21);
        chk("m0_not_done", 64'(done), 64'd0);
        step(9);
        chk("m0_pass_early", 64'(pass), 64'd0);
        step(1);
        chk("m0_pass", 64'(pass), 64'd1);
        chk("m0_id", 64'(pass_id), 64'd0);
        chk("m0_stores", 64'(store_count), 64'd1);
        pop_n(1);
        chk("m0_log_empty", 64'(log_valid), 64'd0);

        // Signature 4 on the watchdog's final cycle: match wins.
        do_reset();
        step(499);
        exp_res.push_back('{pass: 1'b1, id: 3'd4, cc: 32'd500});
        store(64'd100, 64'd6, 2'b11, 1'b0);
        chk("race_no_fail", 64'(done), 64'd0);
        chk("race_cycles", 64'(cycle_count), 64'd500);
        step(10);
        chk("race_pass", 64'(pass), 64'd1);
        chk("race_id", 64'(pass_id), 64'd4);
        chk("race_stores", 64'(store_count), 64'd1);
        pop_n(1);

        // Second signature during DRAIN: counted and logged, not re-matched.
        do_reset();
        step(5);
        exp_res.push_back('{pass: 1'b1, id: 3'd0, cc: 32'd6});
        store(64'd100, 64'd7, 2'b10, 1'b0);
        step(2);
        store(64'd508, 64'd7, 2'b01, 1'b0);
        step(7);
        chk("drain_pass", 64'(pass), 64'd1);
        chk("drain_id", 64'(pass_id), 64'd0);
        chk("drain_stores", 64'(store_count), 64'd2);
        chk("drain_log_valid", 64'(log_valid), 64'd1);
        pop_n(2);
        chk("drain_log_empty", 64'(log_valid), 64'd0);

        // Nine stores without pops: ninth dropped; high address bits defeat a match.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 3)
                store(64'h0000_0001_0000_0064, 64'd7, 2'b01, 1'b0);
            else
                store(64'(32'h1000 + i * 8), 64'hDEAD_0000_0000_0000 + 64'(i), 2'b01, 1'b0);
            if (i == 7) chk("ovf_at_full", 64'(log_ovf), 64'd0);
        end
        chk("ovf_set", 64'(log_ovf), 64'd1);
        chk("ovf_stores", 64'(store_count), 64'd9);
        chk("ovf_cycles", 64'(cycle_count), 64'd9);
        chk("ovf_no_match", 64'(done), 64'd0);
        pop_n(8);
        chk("ovf_log_empty", 64'(log_valid), 64'd0);
        chk("ovf_sticky", 64'(log_ovf), 64'd1);

        // Full log with push+pop together, then reset asserted mid-DRAIN.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            store(64'h2000 + 64'(i), 64'h5500 + 64'(i), 2'b01, 1'b0);
        end
        chk("full_ovf", 64'(log_ovf), 64'd0);
        store(64'h3000, 64'h77, 2'b01, 1'b1);
        chk("pp_ovf", 64'(log_ovf), 64'd0);
        chk("pp_stores", 64'(store_count), 64'd9);
        pop_n(8);
        chk("pp_log_empty", 64'(log_valid), 64'd0);
        store(64'd100, 64'd7, 2'b01, 1'b0);
        step(3);
        reset = 1'b0;
        @(negedge clk);
        chk_zero("midrun");
        exp_log.delete();
        occ = 0;
        step(1);
        reset = 1'b1;
        step(2);

        chk("res_queue_drained", 64'(exp_res.size()), 64'd0);
        chk("log_queue_drained", 64'(exp_log.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
